// File: rtl/vga_capture.sv
// Receive-side VGA timing recovery: locks onto HSYNC/VSYNC edges, rebuilds pixel
// coordinates, emits a registered pixel stream and a per-frame lit-pixel bounding box.
module vga_capture #(
    parameter int unsigned H_TOTAL  = 2160,
    parameter int unsigned V_TOTAL  = 1250,
    parameter int unsigned HS_START = 64,
    parameter int unsigned HS_END   = 255,
    parameter int unsigned VS_START = 1,
    parameter int unsigned VS_END   = 3,
    parameter int unsigned H_VIS    = 560,
    parameter int unsigned V_VIS    = 50,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clock_162,
    input  logic             rst_l,
    input  logic [3:0]       RED,
    input  logic [3:0]       GREEN,
    input  logic [3:0]       BLUE,
    input  logic             HSYNC,
    input  logic             VSYNC,
    output logic             locked,
    output logic             pix_valid,
    output logic [10:0]      pix_x,
    output logic [10:0]      pix_y,
    output logic [11:0]      pix_rgb,
    output logic             frame_start,
    output logic             frame_done,
    output logic             obj_valid,
    output logic [10:0]      obj_min_x,
    output logic [10:0]      obj_max_x,
    output logic [10:0]      obj_min_y,
    output logic [10:0]      obj_max_y,
    output logic             sync_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CW = 12;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_FALL   = CW'(HS_START);
    localparam logic [CW-1:0] HS_RISE   = CW'(HS_END + 1);
    localparam logic [CW-1:0] HS_RELOAD = CW'(HS_START + 1);
    localparam logic [CW-1:0] VS_FALL   = CW'(VS_START);
    localparam logic [CW-1:0] VS_RISE   = CW'(VS_END + 1);
    localparam logic [CW-1:0] H_FIRST   = CW'(H_VIS);
    localparam logic [CW-1:0] V_FIRST   = CW'(V_VIS);
    localparam logic [10:0]   X_LAST    = 11'(H_TOTAL - H_VIS - 1);
    localparam logic [10:0]   Y_LAST    = 11'(V_TOTAL - V_VIS - 1);

    typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

    state_t          state, state_n;
    logic [11:0]     s1_rgb;
    logic            s1_hs, s1_vs, p_hs, p_vs;
    logic [CW-1:0]   hcnt, vcnt, hcnt_n, vcnt_n;
    logic            h_fall, h_rise, v_fall, v_rise;
    logic            err, vis, first_pix;

    logic            lit, last_pix, acc_on;
    logic            acc_any, a_any;
    logic [10:0]     acc_min_x, acc_max_x, acc_min_y, acc_max_y;
    logic [10:0]     a_min_x, a_max_x, a_min_y, a_max_y;

    always_ff @(posedge clock_162 or negedge rst_l) begin
        if (!rst_l) begin
            s1_rgb <= '0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            p_hs   <= 1'b0;
            p_vs   <= 1'b0;
        end else begin
            s1_rgb <= {RED, GREEN, BLUE};
            s1_hs  <= HSYNC;
            s1_vs  <= VSYNC;
            p_hs   <= s1_hs;
            p_vs   <= s1_vs;
        end
    end

    assign h_fall = p_hs & ~s1_hs;
    assign h_rise = ~p_hs & s1_hs;
    assign v_fall = p_vs & ~s1_vs;
    assign v_rise = ~p_vs & s1_vs;

    // hcnt/vcnt name the sample currently in S1, so a reload targets the
    // column of the next sample (edge column + 1).
    always_comb begin
        state_n = state;
        err     = 1'b0;
        hcnt_n  = (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
        vcnt_n  = vcnt;
        if (hcnt == H_LAST) begin
            vcnt_n = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
        case (state)
            SEARCH: begin
                if (h_fall) begin
                    hcnt_n  = HS_RELOAD;
                    state_n = HLOCK;
                end
            end
            HLOCK: begin
                if ((h_fall && hcnt != HS_FALL) || (v_fall && hcnt != '0)) begin
                    err     = 1'b1;
                    state_n = SEARCH;
                end else if (v_fall) begin
                    vcnt_n  = VS_FALL;
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                err = (h_fall && hcnt != HS_FALL)
                   || (h_rise && hcnt != HS_RISE)
                   || (v_fall && !(vcnt == VS_FALL && hcnt == '0))
                   || (v_rise && !(vcnt == VS_RISE && hcnt == '0));
                if (err) begin
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clock_162 or negedge rst_l) begin
        if (!rst_l) begin
            state <= SEARCH;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            vcnt  <= vcnt_n;
        end
    end

    assign locked    = (state == LOCKED);
    assign vis       = (state == LOCKED) && !err && (hcnt >= H_FIRST) && (vcnt >= V_FIRST);
    assign first_pix = vis && (hcnt == H_FIRST) && (vcnt == V_FIRST);

    always_ff @(posedge clock_162 or negedge rst_l) begin
        if (!rst_l) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            pix_valid   <= vis;
            pix_x       <= vis ? 11'(hcnt - H_FIRST) : '0;
            pix_y       <= vis ? 11'(vcnt - V_FIRST) : '0;
            pix_rgb     <= vis ? s1_rgb : '0;
            frame_start <= first_pix;
            sync_err    <= err;
            if (err && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign lit      = pix_valid && (pix_rgb != '0);
    assign last_pix = pix_valid && (pix_x == X_LAST) && (pix_y == Y_LAST);

    // frame_start discards the previous box so the first lit pixel seeds all four bounds.
    always_comb begin
        a_any   = acc_any && !frame_start;
        a_min_x = acc_min_x;
        a_max_x = acc_max_x;
        a_min_y = acc_min_y;
        a_max_y = acc_max_y;
        if (lit) begin
            if (!a_any) begin
                a_min_x = pix_x;
                a_max_x = pix_x;
                a_min_y = pix_y;
                a_max_y = pix_y;
            end else begin
                if (pix_x < a_min_x) a_min_x = pix_x;
                if (pix_x > a_max_x) a_max_x = pix_x;
                if (pix_y < a_min_y) a_min_y = pix_y;
                if (pix_y > a_max_y) a_max_y = pix_y;
            end
            a_any = 1'b1;
        end
    end

    always_ff @(posedge clock_162 or negedge rst_l) begin
        if (!rst_l) begin
            acc_on     <= 1'b0;
            acc_any    <= 1'b0;
            acc_min_x  <= '0;
            acc_max_x  <= '0;
            acc_min_y  <= '0;
            acc_max_y  <= '0;
            frame_done <= 1'b0;
            obj_valid  <= 1'b0;
            obj_min_x  <= '0;
            obj_max_x  <= '0;
            obj_min_y  <= '0;
            obj_max_y  <= '0;
        end else begin
            acc_any    <= a_any;
            acc_min_x  <= a_min_x;
            acc_max_x  <= a_max_x;
            acc_min_y  <= a_min_y;
            acc_max_y  <= a_max_y;
            frame_done <= 1'b0;
            if (err) begin
                acc_on <= 1'b0;
            end else if (frame_start) begin
                acc_on <= 1'b1;
            end
            if (last_pix && acc_on && !err) begin
                frame_done <= 1'b1;
                obj_valid  <= a_any;
                obj_min_x  <= a_any ? a_min_x : '0;
                obj_max_x  <= a_any ? a_max_x : '0;
                obj_min_y  <= a_any ? a_min_y : '0;
                obj_max_y  <= a_any ? a_max_y : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a scaled-down raster: a behavioural VGA source
// with random sprites, injected sync faults and a mid-frame reset, checked against a pin-level model.
module tb_vga_capture;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HSS = 4;
    localparam int HSE = 9;
    localparam int VSS = 1;
    localparam int VSE = 3;
    localparam int HV  = 16;
    localparam int VV  = 6;
    localparam int EW  = 2;
    localparam int VW  = HT - HV;
    localparam int VH  = VT - VV;
    localparam int NF  = 14;
    localparam int FAULT_F  = 4;
    localparam int FAULT_R  = 10;
    localparam int RST_F    = 6;
    localparam int GLITCH_F = 9;
    localparam int ECNT_MAX = (1 << EW) - 1;

    typedef struct packed {
        logic          valid;
        logic [10:0]   x;
        logic [10:0]   y;
        logic [11:0]   rgb;
        logic          fs;
        logic          done;
        logic          err;
        logic          lk;
        logic [EW-1:0] ecnt;
        logic [44:0]   box;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_l;
    logic [3:0]    red, green, blue;
    logic          hs, vs;
    logic          locked, pix_valid, frame_start, frame_done, obj_valid, sync_err;
    logic [10:0]   pix_x, pix_y, obj_min_x, obj_max_x, obj_min_y, obj_max_y;
    logic [11:0]   pix_rgb;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    vga_capture #(
        .H_TOTAL (HT),  .V_TOTAL (VT),
        .HS_START(HSS), .HS_END  (HSE),
        .VS_START(VSS), .VS_END  (VSE),
        .H_VIS   (HV),  .V_VIS   (VV),
        .ERR_W   (EW)
    ) dut (
        .clock_162  (clk),
        .rst_l      (rst_l),
        .RED        (red),
        .GREEN      (green),
        .BLUE       (blue),
        .HSYNC      (hs),
        .VSYNC      (vs),
        .locked     (locked),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .obj_valid  (obj_valid),
        .obj_min_x  (obj_min_x),
        .obj_max_x  (obj_max_x),
        .obj_min_y  (obj_min_y),
        .obj_max_y  (obj_max_y),
        .sync_err   (sync_err),
        .err_count  (err_count)
    );

    int          errors = 0;
    int          checks = 0;
    int          row = 0, col = 0, frame = 0;
    logic [11:0] img [VH][VW];
    logic [44:0] cur_box;
    bit          have_h, lk, acc_on, phs, pvs;
    int          ecnt;
    exp_t        e1, e2;

    function automatic void paint(input int r0, input int c0, input int h, input int w,
                                  input logic [11:0] color);
        for (int r = r0; r < r0 + h; r++)
            for (int c = c0; c < c0 + w; c++)
                if (r >= 0 && r < VH && c >= 0 && c < VW) img[r][c] = color;
    endfunction

    function automatic void setup_image(input int f);
        bit any;
        int mnx, mxx, mny, mxy;
        int n;
        for (int r = 0; r < VH; r++)
            for (int c = 0; c < VW; c++) img[r][c] = '0;
        case (f)
            1: paint(3, 7, 5, 6, 12'hFFF);
            2: paint(-2, -3, 4, 5, 12'hFFF);
            3: ;
            8: paint(VH - 2, VW - 3, 5, 5, 12'h00F);
            default: begin
                n = int'($urandom_range(0, 2));
                for (int k = 0; k < n; k++)
                    paint(int'($urandom_range(0, VH + 2)) - 3, int'($urandom_range(0, VW + 2)) - 3,
                          int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                          12'($urandom_range(1, 4095)));
            end
        endcase
        any = 0; mnx = 0; mxx = 0; mny = 0; mxy = 0;
        for (int r = 0; r < VH; r++)
            for (int c = 0; c < VW; c++)
                if (img[r][c] != 0) begin
                    if (!any) begin
                        mnx = c; mxx = c; mny = r; mxy = r; any = 1;
                    end else begin
                        if (c < mnx) mnx = c;
                        if (c > mxx) mxx = c;
                        if (r < mny) mny = r;
                        if (r > mxy) mxy = r;
                    end
                end
        cur_box = any ? {1'b1, 11'(mnx), 11'(mxx), 11'(mny), 11'(mxy)} : '0;
    endfunction

    task automatic check_all_zero(input string tag);
        checks++;
        assert ({locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done, obj_valid,
                 obj_min_x, obj_max_x, obj_min_y, obj_max_y, sync_err, err_count} === '0)
        else begin
            errors++;
            $error("FAIL %s: outputs lk=%b pv=%b x=%0d y=%0d rgb=%h fs=%b fd=%b ov=%b box=%0d,%0d,%0d,%0d se=%b ec=%0d, required all zero",
                   tag, locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done, obj_valid,
                   obj_min_x, obj_max_x, obj_min_y, obj_max_y, sync_err, err_count);
        end
    endtask

    // One raster position: drive pins, predict the DUT's view of that sample, clock, check.
    task automatic step();
        exp_t        e;
        bit          h, v, hf, hr, vf, vr, er, visible;
        logic [11:0] rgb;
        if (row == 0 && col == 0) setup_image(frame);
        h = !(col >= HSS && col <= HSE);
        if (frame == FAULT_F && row == FAULT_R && col == HSE + 1) h = 0;
        if (frame == GLITCH_F && (col == 12 || col == 13)) h = 0;
        v = !(row >= VSS && row <= VSE);
        visible = (row >= VV) && (col >= HV);
        rgb = visible ? img[row - VV][col - HV] : 12'($urandom_range(0, 4095));
        {red, green, blue} = rgb;
        hs = h;
        vs = v;
        e = '0;
        if (rst_l) begin
            hf = phs && !h;
            hr = !phs && h;
            vf = pvs && !v;
            vr = !pvs && v;
            er = 0;
            if (lk)
                er = (hf && col != HSS) || (hr && col != HSE + 1)
                  || (vf && !(row == VSS && col == 0)) || (vr && !(row == VSE + 1 && col == 0));
            else if (have_h)
                er = (hf && col != HSS) || (vf && col != 0);
            e.valid = lk && !er && visible;
            if (e.valid) begin
                e.x   = 11'(col - HV);
                e.y   = 11'(row - VV);
                e.rgb = rgb;
            end
            e.fs = e.valid && col == HV && row == VV;
            if (er) begin
                lk = 0;
                have_h = 0;
                acc_on = 0;
                if (ecnt < ECNT_MAX) ecnt++;
            end else if (!lk && have_h && vf) begin
                lk = 1;
            end else if (!lk && hf) begin
                have_h = 1;
            end
            if (e.fs) acc_on = 1;
            e.done = e.valid && acc_on && col == HT - 1 && row == VT - 1;
            e.box  = cur_box;
            e.err  = er;
            e.lk   = lk;
            e.ecnt = EW'(ecnt);
            phs = h;
            pvs = v;
        end
        @(posedge clk);
        #1;
        checks++;
        assert ({pix_valid, pix_x, pix_y, pix_rgb} === {e1.valid, e1.x, e1.y, e1.rgb})
        else begin
            errors++;
            $error("FAIL pix f%0d r%0d c%0d: got v=%b x=%0d y=%0d rgb=%h, want v=%b x=%0d y=%0d rgb=%h",
                   frame, row, col, pix_valid, pix_x, pix_y, pix_rgb, e1.valid, e1.x, e1.y, e1.rgb);
        end
        checks++;
        assert ({frame_start, sync_err, locked, err_count} === {e1.fs, e1.err, e1.lk, e1.ecnt})
        else begin
            errors++;
            $error("FAIL flags f%0d r%0d c%0d: got fs=%b se=%b lk=%b ec=%0d, want fs=%b se=%b lk=%b ec=%0d",
                   frame, row, col, frame_start, sync_err, locked, err_count, e1.fs, e1.err, e1.lk, e1.ecnt);
        end
        checks++;
        assert (frame_done === e2.done)
        else begin
            errors++;
            $error("FAIL frame_done f%0d r%0d c%0d: got %b, want %b", frame, row, col, frame_done, e2.done);
        end
        if (e2.done) begin
            checks++;
            assert ({obj_valid, obj_min_x, obj_max_x, obj_min_y, obj_max_y} === e2.box)
            else begin
                errors++;
                $error("FAIL bbox f%0d: got v=%b x=%0d..%0d y=%0d..%0d, want v=%b x=%0d..%0d y=%0d..%0d",
                       frame, obj_valid, obj_min_x, obj_max_x, obj_min_y, obj_max_y,
                       e2.box[44], e2.box[43:33], e2.box[32:22], e2.box[21:11], e2.box[10:0]);
            end
        end
        e2 = e1;
        e1 = e;
        if (col == HT - 1) begin
            col = 0;
            if (row == VT - 1) begin
                row = 0;
                frame++;
            end else begin
                row++;
            end
        end else begin
            col++;
        end
    endtask

    task automatic model_reset();
        lk = 0; have_h = 0; acc_on = 0; ecnt = 0; phs = 0; pvs = 0;
        e1 = '0; e2 = '0;
    endtask

    task automatic mid_reset();
        rst_l = 1'b0;
        #1;
        check_all_zero("mid_frame_reset");
        model_reset();
        repeat (3) step();
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l = 1'b0;
        {red, green, blue} = '0;
        hs = 1'b1;
        vs = 1'b1;
        cur_box = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst_l = 1'b1;
        for (int n = 0; n < NF * HT * VT + 4; n++) begin
            if (frame == RST_F && row == VV + 5 && col == 20) mid_reset();
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
